// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } uart_state_e;

   function automatic int unsigned uart_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous input; resets to 1.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, 1 stop bit, single-entry valid/ready buffer.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int unsigned DIV  = uart_div(CLK_FREQ, BAUD);
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV);
   localparam int unsigned BW   = $clog2(DATA_BITS);

   localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   if (DIV < 4) begin : g_bad_div
      $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
   end

   logic rxs;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_d       = bit_q;
      shift_d     = shift_q;
      par_bad_d   = par_bad_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err   = 1'b0;
      overrun_err = 1'b0;
      parity_err  = 1'b0;

      // Drain; a good stop sample in the same cycle overrides this below.
      if (valid_q && rd_ready) begin
         valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            cnt_d     = '0;
            par_bad_d = 1'b0;
            if (!rxs) begin
               state_d = StStart;
            end
         end
         StStart: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rxs ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == DIV_M1) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (cnt_q == DIV_M1) begin
               cnt_d     = '0;
               par_bad_d = (rxs != ^shift_q);
               state_d   = StStop;
            end
         end
`endif
         StStop: begin
            if (cnt_q == DIV_M1) begin
               cnt_d = '0;
`ifdef UART_RX_PARITY_EN
               parity_err = par_bad_q;
`endif
               if (!rxs) begin
                  frame_err = 1'b1;
                  state_d   = StBreak;
               end else begin
                  // Back to idle at mid-stop so a following start edge is not missed.
                  state_d = StIdle;
                  if (!par_bad_q) begin
                     if (!valid_q || rd_ready) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                     end else begin
                        overrun_err = 1'b1;
                     end
                  end
               end
            end
         end
         StBreak: begin
            cnt_d = '0;
            if (rxs) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign rd_data  = data_q;
   assign rd_valid = valid_q;
   assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed checks.
module tb_uart_rx;

   localparam int unsigned DIV  = 434;
   localparam int unsigned HALF = 217;
`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;
   logic       busy;

   uart_rx #(
      .CLK_FREQ (50000000),
      .BAUD     (115200)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err),
      .busy        (busy)
   );

   always #10 clk = ~clk;

   // One entry per complete frame on the line: the clock edge that ends its stop-sample cycle.
   typedef struct {
      longint     e;
      logic [7:0] d;
      bit         stop_ok;
      bit         par_ok;
   } frame_t;

   frame_t     fq[$];
   longint     cyc = 0;
   logic       exp_valid;
   logic [7:0] exp_data;
   int         n_chk  = 0;
   int         n_fail = 0;
   bit         chk_en = 1'b0;
   int         fe_cnt = 0;
   int         oe_cnt = 0;
   int         pe_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Buffer model: load on a good frame if empty or drained in the same cycle.
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         exp_valid = 1'b0;
         exp_data  = 8'h00;
         fq.delete();
      end else begin
         bit loaded;
         loaded = 1'b0;
         if (fq.size() > 0 && fq[0].e == cyc) begin
            if (fq[0].stop_ok && fq[0].par_ok && (!exp_valid || rd_ready)) begin
               exp_valid = 1'b1;
               exp_data  = fq[0].d;
               loaded    = 1'b1;
            end
            void'(fq.pop_front());
         end
         if (!loaded && exp_valid && rd_ready) begin
            exp_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !reset) begin
         bit stop_cyc, exp_fe, exp_oe, exp_pe;
         stop_cyc = (fq.size() > 0) && (fq[0].e == cyc + 1);
         exp_fe = 1'b0;
         exp_oe = 1'b0;
         exp_pe = 1'b0;
         if (stop_cyc) begin
            exp_fe = !fq[0].stop_ok;
            exp_pe = !fq[0].par_ok;
            exp_oe = fq[0].stop_ok && fq[0].par_ok && exp_valid && !rd_ready;
         end
         check("rd_valid", rd_valid, exp_valid);
         check("rd_data", rd_data, exp_data);
         check("frame_err", frame_err, exp_fe);
         check("overrun_err", overrun_err, exp_oe);
         check("parity_err", parity_err, exp_pe);
         if (frame_err) fe_cnt++;
         if (overrun_err) oe_cnt++;
         if (parity_err) pe_cnt++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; drives nb line bits, each DIV clocks long.
   task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                             input int nb, input bit ready_at_stop);
      logic [10:0] bits;
      frame_t      f;
      bits      = '1;
      bits[0]   = 1'b0;
      bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
      bits[9] = (^d) ^ par_flip;
`endif
      bits[NB-1] = stop;
      if (nb == NB) begin
         f.e       = cyc + 3 + HALF + (NB - 1) * DIV;
         f.d       = d;
         f.stop_ok = stop;
         f.par_ok  = !par_flip;
         fq.push_back(f);
      end
      for (int b = 0; b < nb; b++) begin
         rx = bits[b];
         if (ready_at_stop && b == NB - 1) begin
            repeat (HALF + 2) @(posedge clk);
            #1 rd_ready = 1'b1;
            @(posedge clk);
            #1 rd_ready = 1'b0;
            repeat (DIV - HALF - 3) @(posedge clk);
         end else begin
            repeat (DIV) @(posedge clk);
         end
         #1;
      end
   endtask

   task automatic drain();
      rd_ready = 1'b1;
      step(1);
      rd_ready = 1'b0;
      check("drain_valid", rd_valid, 1'b0);
   endtask

   initial begin
      rx       = 1'b1;
      rd_ready = 1'b0;
      reset    = 1'b1;
      #100 reset = 1'b0;
      step(1);
      check("rst_valid", rd_valid, 1'b0);
      check("rst_data", rd_data, 8'h00);
      check("rst_errs", {frame_err, overrun_err, parity_err}, 3'b000);
      check("rst_busy", busy, 1'b0);
      chk_en = 1'b1;
      step(10000);

      // 0xA5: rd_valid rises exactly 3+HALF+9*DIV = 4126 clocks after the start bit is driven.
      fork
         send_frame(8'hA5, 1'b1, 1'b0, NB, 1'b0);
         begin
            step(4125 + ((NB == 11) ? DIV : 0));
            check("a5_before", rd_valid, 1'b0);
            step(1);
            check("a5_rise", rd_valid, 1'b1);
         end
      join
      check("a5_data", rd_data, 8'hA5);
      check("a5_idle", busy, 1'b0);
      step(50);
      check("a5_stable", rd_data, 8'hA5);
      drain();

      // Start glitch shorter than HALF.
      rx = 1'b0;
      step(100);
      rx = 1'b1;
      step(5);
      check("glitch_busy", busy, 1'b1);
      step(125);
      check("glitch_idle", busy, 1'b0);

      // Bad stop bit followed by a held-low line.
      send_frame(8'h3C, 1'b0, 1'b0, NB, 1'b0);
      step(2000);
      check("break_busy", busy, 1'b1);
      check("break_fe_cnt", fe_cnt, 1);
      rx = 1'b1;
      step(10);
      check("break_idle", busy, 1'b0);
      send_frame(8'h81, 1'b1, 1'b0, NB, 1'b0);
      check("after_break_data", rd_data, 8'h81);
      check("after_break_fe", fe_cnt, 1);
      drain();

      // Overrun, then simultaneous drain and fill.
      send_frame(8'h11, 1'b1, 1'b0, NB, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, NB, 1'b0);
      check("ovr_data", rd_data, 8'h11);
      check("ovr_cnt", oe_cnt, 1);
      drain();
      send_frame(8'h11, 1'b1, 1'b0, NB, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, NB, 1'b1);
      check("fill_data", rd_data, 8'h22);
      check("fill_valid", rd_valid, 1'b1);
      check("fill_ovr_cnt", oe_cnt, 1);

      // Reset during data bit 4 of 0xF0 while 0x22 is still buffered.
      send_frame(8'hF0, 1'b1, 1'b0, 5, 1'b0);
      rx = 1'b1;
      step(HALF);
      check("mid_busy", busy, 1'b1);
      reset = 1'b1;
      step(3);
      reset = 1'b0;
      step(2);
      check("mid_rst_valid", rd_valid, 1'b0);
      check("mid_rst_data", rd_data, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0, NB, 1'b0);
      check("post_rst_data", rd_data, 8'h0F);
      check("post_rst_valid", rd_valid, 1'b1);
      drain();

`ifdef UART_RX_PARITY_EN
      // 0x07 has odd weight, so an even-parity bit of 0 is wrong.
      send_frame(8'h07, 1'b1, 1'b1, NB, 1'b0);
      check("par_cnt", pe_cnt, 1);
      check("par_valid", rd_valid, 1'b0);
`else
      check("par_cnt", pe_cnt, 0);
`endif
      check("final_fe_cnt", fe_cnt, 1);
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
